// File: rtl/axi_sram_responder_if.sv
// AXI4-Lite-style channel bundle between a memory master and the SRAM responder.
// Carries AR/R and AW/W/B handshakes; clock and reset stay outside the bundle.
interface axi_sram_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
);
  logic                      ar_valid;
  logic                      ar_ready;
  logic [ADDR_WIDTH-1:0]     ar_addr;
  logic                      r_valid;
  logic                      r_ready;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [1:0]                r_resp;
  logic                      aw_valid;
  logic                      aw_ready;
  logic [ADDR_WIDTH-1:0]     aw_addr;
  logic                      w_valid;
  logic                      w_ready;
  logic [DATA_WIDTH-1:0]     w_data;
  logic [DATA_WIDTH/8-1:0]   w_strb;
  logic                      b_valid;
  logic                      b_ready;
  logic [1:0]                b_resp;

  modport master (
    output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/axi_sram_responder.sv
// AXI4-Lite-style responder backing a word-addressed 64-bit SRAM.
// Independent read and write FSMs with programmable wait latency for stall testing.
module axi_sram_responder #(
  parameter int unsigned               AXI_DATA_WIDTH = 64,
  parameter int unsigned               AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = AXI_ADDR_WIDTH'(32'h8000_0000),
  parameter int unsigned               DEPTH_LOG2     = 12,
  parameter int unsigned               RD_LAT         = 2,
  parameter int unsigned               WR_LAT         = 1
) (
  input logic                  clk,
  input logic                  rst,
  axi_sram_responder_if.slave  s_axi
);

  localparam int unsigned             StrbWidth = AXI_DATA_WIDTH / 8;
  localparam int unsigned             Depth     = 1 << DEPTH_LOG2;
  localparam logic [AXI_ADDR_WIDTH:0] SpanBytes = (AXI_ADDR_WIDTH + 1)'(8) << DEPTH_LOG2;
  localparam logic [3:0]              RdLatCnt  = 4'(RD_LAT);
  localparam logic [3:0]              WrLatCnt  = 4'(WR_LAT);
  localparam logic [1:0]              RespOkay  = 2'b00;
  localparam logic [1:0]              RespDec   = 2'b11;

  if (AXI_DATA_WIDTH != 64) begin : g_width_check
    $error("AXI_DATA_WIDTH must be 64");
  end
  if (RD_LAT > 15) begin : g_rd_lat_check
    $error("RD_LAT must be in 0..15");
  end
  if (WR_LAT > 15) begin : g_wr_lat_check
    $error("WR_LAT must be in 0..15");
  end

  typedef enum logic [1:0] {StRdIdle, StRdWait, StRdResp} rd_state_e;
  typedef enum logic [1:0] {StWrIdle, StWrWait, StWrResp} wr_state_e;

  logic [AXI_DATA_WIDTH-1:0] mem [Depth];

  function automatic logic addr_hit(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a >= BASE_ADDR) && (off < SpanBytes);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return DEPTH_LOG2'(off >> 3);
  endfunction

  // Read path
  rd_state_e                 rd_state_q, rd_state_d;
  logic [3:0]                rd_cnt_q, rd_cnt_d;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]                r_resp_q, r_resp_d;
  logic                      rd_sample;
  logic [AXI_ADDR_WIDTH-1:0] rd_sample_addr;

  always_comb begin
    rd_state_d     = rd_state_q;
    rd_cnt_d       = rd_cnt_q;
    rd_addr_d      = rd_addr_q;
    r_data_d       = r_data_q;
    r_resp_d       = r_resp_q;
    rd_sample      = 1'b0;
    rd_sample_addr = rd_addr_q;
    unique case (rd_state_q)
      StRdIdle: begin
        if (s_axi.ar_valid) begin
          rd_addr_d = s_axi.ar_addr;
          rd_cnt_d  = RdLatCnt;
          if (RD_LAT == 0) begin
            rd_sample      = 1'b1;
            rd_sample_addr = s_axi.ar_addr;
            rd_state_d     = StRdResp;
          end else begin
            rd_state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        rd_cnt_d = rd_cnt_q - 4'd1;
        if (rd_cnt_q <= 4'd1) begin
          rd_sample  = 1'b1;
          rd_state_d = StRdResp;
        end
      end
      StRdResp: begin
        if (s_axi.r_ready) begin
          rd_state_d = StRdIdle;
          r_data_d   = '0;
          r_resp_d   = RespOkay;
        end
      end
      default: rd_state_d = StRdIdle;
    endcase
    // Samples the pre-commit word when a write lands on the same edge.
    if (rd_sample) begin
      if (addr_hit(rd_sample_addr)) begin
        r_data_d = mem[addr_idx(rd_sample_addr)];
        r_resp_d = RespOkay;
      end else begin
        r_data_d = '0;
        r_resp_d = RespDec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= StRdIdle;
      rd_cnt_q   <= '0;
      rd_addr_q  <= '0;
      r_data_q   <= '0;
      r_resp_q   <= RespOkay;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_addr_q  <= rd_addr_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  assign s_axi.ar_ready = !rst && (rd_state_q == StRdIdle);
  assign s_axi.r_valid  = !rst && (rd_state_q == StRdResp);
  assign s_axi.r_data   = rst ? '0 : r_data_q;
  assign s_axi.r_resp   = rst ? RespOkay : r_resp_q;

  // Write path
  wr_state_e                 wr_state_q, wr_state_d;
  logic [3:0]                wr_cnt_q, wr_cnt_d;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [StrbWidth-1:0]      w_strb_q, w_strb_d;
  logic                      aw_got_q, aw_got_d;
  logic                      w_got_q, w_got_d;
  logic [1:0]                b_resp_q, b_resp_d;
  logic                      aw_hs, w_hs, commit;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    b_resp_d   = b_resp_q;
    commit     = 1'b0;
    aw_hs      = (wr_state_q == StWrIdle) && !aw_got_q && s_axi.aw_valid;
    w_hs       = (wr_state_q == StWrIdle) && !w_got_q && s_axi.w_valid;
    unique case (wr_state_q)
      StWrIdle: begin
        if (aw_hs) begin
          aw_addr_d = s_axi.aw_addr;
          aw_got_d  = 1'b1;
        end
        if (w_hs) begin
          w_data_d = s_axi.w_data;
          w_strb_d = s_axi.w_strb;
          w_got_d  = 1'b1;
        end
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          wr_state_d = StWrWait;
          wr_cnt_d   = WrLatCnt;
        end
      end
      StWrWait: begin
        if (wr_cnt_q <= 4'd1) begin
          commit     = 1'b1;
          wr_cnt_d   = '0;
          b_resp_d   = addr_hit(aw_addr_q) ? RespOkay : RespDec;
          wr_state_d = StWrResp;
        end else begin
          wr_cnt_d = wr_cnt_q - 4'd1;
        end
      end
      StWrResp: begin
        if (s_axi.b_ready) begin
          wr_state_d = StWrIdle;
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          b_resp_d   = RespOkay;
        end
      end
      default: wr_state_d = StWrIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= StWrIdle;
      wr_cnt_q   <= '0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      b_resp_q   <= RespOkay;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      b_resp_q   <= b_resp_d;
    end
  end

  // SRAM array has no reset; an aborted write never reaches it.
  always_ff @(posedge clk) begin
    if (commit && !rst && addr_hit(aw_addr_q)) begin
      for (int i = 0; i < int'(StrbWidth); i++) begin
        if (w_strb_q[i]) begin
          mem[addr_idx(aw_addr_q)][8*i +: 8] <= w_data_q[8*i +: 8];
        end
      end
    end
  end

  assign s_axi.aw_ready = !rst && (wr_state_q == StWrIdle) && !aw_got_q;
  assign s_axi.w_ready  = !rst && (wr_state_q == StWrIdle) && !w_got_q;
  assign s_axi.b_valid  = !rst && (wr_state_q == StWrResp);
  assign s_axi.b_resp   = rst ? RespOkay : b_resp_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Scoreboard bench for axi_sram_responder: randomized traffic against a word-array model,
// with a decoupled monitor checking every R and B beat plus hold-under-backpressure.
module tb_axi_sram_responder;
  localparam logic [31:0] Base  = 32'h8000_0000;
  localparam logic [31:0] Limit = 32'h8000_8000;
  localparam int          RdLat = 2;
  localparam int          WrLat = 1;
  localparam int          Win   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_sram_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

  axi_sram_responder #(
    .AXI_DATA_WIDTH(64),
    .AXI_ADDR_WIDTH(32),
    .BASE_ADDR     (Base),
    .DEPTH_LOG2    (12),
    .RD_LAT        (RdLat),
    .WR_LAT        (WrLat)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .s_axi(bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          rd_done = 0;
  int          wr_done = 0;
  int          r_hold = 0;
  int          b_hold = 0;
  bit          rand_bp = 1'b0;
  logic [63:0] model [int];
  logic [65:0] rq [$];
  logic [1:0]  bq [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= Base) && (a < Limit);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - Base) >> 3);
  endfunction

  function automatic logic [65:0] model_read(input logic [31:0] a);
    if (in_range(a)) return {2'b00, model[word_of(a)]};
    return {2'b11, 64'h0};
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [63:0] d,
                                             input logic [7:0] s);
    logic [63:0] w;
    if (!in_range(a)) return 2'b11;
    w = model[word_of(a)];
    for (int i = 0; i < 8; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    model[word_of(a)] = w;
    return 2'b00;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k == 0) return Base - 32'(8 * $urandom_range(1, 4)) + 32'($urandom_range(0, 7));
    if (k == 1) return Limit + 32'($urandom_range(0, 255));
    return Base + 32'(8 * $urandom_range(0, Win - 1)) + 32'($urandom_range(0, 7));
  endfunction

  // Ready generator: forced stalls first, otherwise random or always-ready.
  initial begin
    bus.r_ready = 1'b0;
    bus.b_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.r_valid && r_hold > 0) begin
        bus.r_ready = 1'b0;
        r_hold--;
      end else begin
        bus.r_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (bus.b_valid && b_hold > 0) begin
        bus.b_ready = 1'b0;
        b_hold--;
      end else begin
        bus.b_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each completed beat and checks stall stability.
  initial begin
    logic [65:0] e;
    logic [63:0] pr_data;
    logic [1:0]  pr_resp, pb_resp;
    bit          pr_stall, pb_stall;
    pr_stall = 1'b0;
    pb_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_ctrl", 64'({bus.ar_ready, bus.r_valid, bus.aw_ready, bus.w_ready, bus.b_valid,
                               bus.r_resp, bus.b_resp}), 64'h0);
        check("rst_r_data", bus.r_data, 64'h0);
        pr_stall = 1'b0;
        pb_stall = 1'b0;
      end else begin
        if (pr_stall) begin
          check("r_hold_valid", 64'(bus.r_valid), 64'h1);
          check("r_hold_data", bus.r_data, pr_data);
          check("r_hold_resp", 64'(bus.r_resp), 64'(pr_resp));
        end
        if (bus.r_valid) begin
          check("ar_ready_busy", 64'(bus.ar_ready), 64'h0);
          if (bus.r_ready) begin
            if (rq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL r_unexpected: beat data %h resp %b, none outstanding",
                       bus.r_data, bus.r_resp);
            end else begin
              e = rq.pop_front();
              check("r_data", bus.r_data, e[63:0]);
              check("r_resp", 64'(bus.r_resp), 64'(e[65:64]));
            end
            rd_done++;
          end
        end
        pr_stall = bus.r_valid && !bus.r_ready;
        pr_data  = bus.r_data;
        pr_resp  = bus.r_resp;
        if (pb_stall) begin
          check("b_hold_valid", 64'(bus.b_valid), 64'h1);
          check("b_hold_resp", 64'(bus.b_resp), 64'(pb_resp));
        end
        if (bus.b_valid && bus.b_ready) begin
          if (bq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected: resp %b, none outstanding", bus.b_resp);
          end else begin
            check("b_resp", 64'(bus.b_resp), 64'(bq.pop_front()));
          end
          wr_done++;
        end
        pb_stall = bus.b_valid && !bus.b_ready;
        pb_resp  = bus.b_resp;
      end
    end
  end

  task automatic do_read(input logic [31:0] addr);
    int target, lat;
    bit hs;
    rq.push_back(model_read(addr));
    target       = rd_done + 1;
    bus.ar_addr  = addr;
    bus.ar_valid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = bus.ar_ready;
      @(posedge clk);
      #1;
    end
    bus.ar_valid = 1'b0;
    if (!hs) begin
      timeout("ar_handshake");
      return;
    end
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (bus.r_valid) break;
    end
    check("rd_latency", 64'(lat), 64'(RdLat + 1));
    for (int i = 0; i < 100 && rd_done < target; i++) begin
      @(posedge clk);
      #1;
    end
    if (rd_done < target) timeout("r_beat");
    @(posedge clk);
    #1;
  endtask

  // da/dw: cycle at which AW/W valid is first raised.
  task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input int da, input int dw);
    int  target, cyc, lat;
    bit  a_done, w_done, ah, wh;
    bq.push_back(model_write(addr, data, strb));
    target      = wr_done + 1;
    bus.aw_addr = addr;
    bus.w_data  = data;
    bus.w_strb  = strb;
    a_done = 1'b0;
    w_done = 1'b0;
    cyc    = 0;
    while (!(a_done && w_done) && cyc < 100) begin
      if (cyc == da) bus.aw_valid = 1'b1;
      if (cyc == dw) bus.w_valid = 1'b1;
      @(negedge clk);
      if (a_done) check("aw_ready_after_aw", 64'(bus.aw_ready), 64'h0);
      if (w_done) check("w_ready_after_w", 64'(bus.w_ready), 64'h0);
      ah = bus.aw_valid && bus.aw_ready;
      wh = bus.w_valid && bus.w_ready;
      @(posedge clk);
      #1;
      if (ah) begin bus.aw_valid = 1'b0; a_done = 1'b1; end
      if (wh) begin bus.w_valid = 1'b0; w_done = 1'b1; end
      cyc++;
    end
    if (!(a_done && w_done)) begin
      bus.aw_valid = 1'b0;
      bus.w_valid  = 1'b0;
      timeout("aw_w_handshake");
      return;
    end
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (bus.b_valid) break;
    end
    check("wr_latency", 64'(lat), 64'(WrLat + 1));
    for (int i = 0; i < 100 && wr_done < target; i++) begin
      @(posedge clk);
      #1;
    end
    if (wr_done < target) timeout("b_beat");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    bus.ar_valid = 1'b0;
    bus.ar_addr  = '0;
    bus.aw_valid = 1'b0;
    bus.aw_addr  = '0;
    bus.w_valid  = 1'b0;
    bus.w_data   = '0;
    bus.w_strb   = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_ar_ready", 64'(bus.ar_ready), 64'h1);
    check("idle_aw_ready", 64'(bus.aw_ready), 64'h1);
    check("idle_w_ready", 64'(bus.w_ready), 64'h1);
    @(posedge clk);
    #1;

    for (int i = 0; i < Win; i++) do_write(Base + 32'(8 * i), {$urandom, $urandom}, 8'hFF, 0, 0);
    do_write(Limit - 32'h8, {$urandom, $urandom}, 8'hFF, 0, 0);

    // Full write then read back; byte lane merge on the same word.
    do_write(Base + 32'h10, 64'h1122_3344_5566_7788, 8'hFF, 0, 0);
    do_read(Base + 32'h10);
    do_write(Base + 32'h10, 64'h0000_00AB_0000_0000, 8'h10, 0, 0);
    do_read(Base + 32'h10);

    // AW leads W by three cycles, then W leads AW.
    do_write(Base + 32'h18, {$urandom, $urandom}, 8'hFF, 0, 3);
    do_read(Base + 32'h18);
    do_write(Base + 32'h20, {$urandom, $urandom}, 8'h0F, 2, 0);
    do_read(Base + 32'h20);

    // Five stalled cycles on both response channels.
    b_hold = 5;
    do_write(Base + 32'h28, {$urandom, $urandom}, 8'hA5, 0, 0);
    r_hold = 5;
    do_read(Base + 32'h28);

    // Decode boundaries and a null strobe.
    do_read(32'h7FFF_FFF8);
    do_write(Limit, {$urandom, $urandom}, 8'hFF, 0, 0);
    do_read(Base);
    do_read(Limit - 32'h8);
    do_read(Limit);
    do_write(Base + 32'h8, {$urandom, $urandom}, 8'h00, 0, 0);
    do_read(Base + 32'h8);

    // Reset while both FSMs wait: no beats, no commit.
    bus.ar_addr  = Base + 32'h30;
    bus.ar_valid = 1'b1;
    bus.aw_addr  = Base + 32'h38;
    bus.aw_valid = 1'b1;
    bus.w_data   = ~model[7];
    bus.w_strb   = 8'hFF;
    bus.w_valid  = 1'b1;
    @(negedge clk);
    check("abort_ar_ready", 64'(bus.ar_ready), 64'h1);
    check("abort_aw_w_ready", 64'({bus.aw_ready, bus.w_ready}), 64'h3);
    @(posedge clk);
    #1;
    bus.ar_valid = 1'b0;
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ar_ready_after_rst", 64'(bus.ar_ready), 64'h1);
    check("aw_ready_after_rst", 64'(bus.aw_ready), 64'h1);
    for (int i = 0; i < 6; i++) begin
      check("no_beat_after_abort", 64'({bus.r_valid, bus.b_valid}), 64'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    do_read(Base + 32'h38);
    do_read(Base + 32'h30);

    rand_bp = 1'b1;
    repeat (200) begin
      a = rand_addr();
      if ($urandom_range(0, 1) == 0) begin
        do_read(a);
      end else if ($urandom_range(0, 1) == 0) begin
        do_write(a, {$urandom, $urandom}, 8'($urandom_range(0, 255)), 0, $urandom_range(0, 3));
      end else begin
        do_write(a, {$urandom, $urandom}, 8'($urandom_range(0, 255)), $urandom_range(0, 3), 0);
      end
    end
    rand_bp = 1'b0;
    repeat (5) @(posedge clk);
    check("rq_drained", 64'(rq.size()), 64'h0);
    check("bq_drained", 64'(bq.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
